// File: rtl/mc_ctrl_trap.sv
// Multi-cycle MIPS control FSM with bounded memory waits, bus timeout,
// precise traps (illegal opcode, overflow, interrupt) through a single TRAP state.
module mc_ctrl_trap #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          TRAP_OVF    = 1'b1,
  parameter bit          INT_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst_in,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  input  logic        int_req,
  output logic        int_ack,
  output logic [1:0]  cause,
  output logic        EPCWrite,
  output logic [4:0]  state_out,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        IorD,
  output logic        CPU_MIO,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALU_operation
);

  typedef enum logic [4:0] {
    S_IF = 5'd0, S_ID = 5'd1, S_MEM_EX = 5'd2, S_MEM_RD = 5'd3, S_LW_WB = 5'd4,
    S_MEM_W = 5'd5, S_R_EXC = 5'd6, S_R_WB = 5'd7, S_BEQ = 5'd8, S_J = 5'd9,
    S_I_EXC = 5'd10, S_I_WB = 5'd11, S_LUI = 5'd12, S_BNE = 5'd13, S_JR = 5'd14,
    S_JAL = 5'd15, S_JALR = 5'd16, S_TRAP = 5'd17
  } state_t;

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
    OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_XORI = 6'b001110,
    OP_SLTI = 6'b001010, OP_LUI = 6'b001111, OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
    OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
    F_OR = 6'b100101, F_NOR = 6'b100111, F_SLT = 6'b101010, F_SRL = 6'b000010,
    F_XOR = 6'b100110, F_JR = 6'b001000, F_JALR = 6'b001001;
  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010, A_XOR = 3'b011,
    A_NOR = 3'b100, A_SRL = 3'b101, A_SUB = 3'b110, A_SLT = 3'b111;

  state_t          state_q, state_d;
  logic [1:0]      cause_q, cause_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            if_entry_q, if_entry_d;
  logic [5:0]      op, funct;
  logic            mem_state, timeout, int_take, fetch_go;
  logic [1:0]      aluop;
  logic            unused_ok;

  assign op        = Inst_in[31:26];
  assign funct     = Inst_in[5:0];
  assign unused_ok = ^{zero, Inst_in[25:6]};

  // Next-state, trap cause and wait-counter selection
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    mem_state = (state_q == S_IF) || (state_q == S_MEM_RD) || (state_q == S_MEM_W);
    timeout   = (MEM_TIMEOUT != 0) && mem_state && !MIO_ready && (wait_cnt_q == WAIT_LAST);
    int_take  = INT_EN && (state_q == S_IF) && if_entry_q && int_req;
    case (state_q)
      S_IF: begin
        if (int_take) begin
          state_d = S_TRAP; cause_d = 2'd0;
        end else if (MIO_ready) begin
          state_d = S_ID;
        end else if (timeout) begin
          state_d = S_TRAP; cause_d = 2'd3;
        end
      end
      S_ID: begin
        case (op)
          OP_R:    state_d = (funct == F_JR) ? S_JR : (funct == F_JALR) ? S_JALR : S_R_EXC;
          OP_LW, OP_SW: state_d = S_MEM_EX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_d = S_I_EXC;
          OP_LUI:  state_d = S_LUI;
          OP_BEQ:  state_d = S_BEQ;
          OP_BNE:  state_d = S_BNE;
          OP_J:    state_d = S_J;
          OP_JAL:  state_d = S_JAL;
          default: begin
            state_d = S_TRAP; cause_d = 2'd1;
          end
        endcase
      end
      S_MEM_EX: state_d = Inst_in[29] ? S_MEM_W : S_MEM_RD;
      S_MEM_RD, S_MEM_W: begin
        if (MIO_ready) begin
          state_d = (state_q == S_MEM_RD) ? S_LW_WB : S_IF;
        end else if (timeout) begin
          state_d = S_TRAP; cause_d = 2'd3;
        end
      end
      S_R_EXC: begin
        if (TRAP_OVF && overflow && (funct == F_ADD || funct == F_SUB)) begin
          state_d = S_TRAP; cause_d = 2'd2;
        end else begin
          state_d = S_R_WB;
        end
      end
      S_I_EXC: begin
        if (TRAP_OVF && overflow && op == OP_ADDI) begin
          state_d = S_TRAP; cause_d = 2'd2;
        end else begin
          state_d = S_I_WB;
        end
      end
      S_LW_WB, S_R_WB, S_I_WB, S_LUI, S_BEQ, S_BNE, S_J, S_JAL, S_JR, S_JALR, S_TRAP:
        state_d = S_IF;
      default: begin
        state_d = S_TRAP; cause_d = 2'd1;
      end
    endcase
    // Counter runs only while a memory state is held; any state change clears it
    wait_cnt_d = (mem_state && state_d == state_q) ? wait_cnt_q + 1'b1 : '0;
    if_entry_d = (state_d == S_IF) && (state_q != S_IF);
  end

  // State, cause, wait counter and IF-entry flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IF;
      cause_q    <= 2'd0;
      wait_cnt_q <= '0;
      if_entry_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      wait_cnt_q <= wait_cnt_d;
      if_entry_q <= if_entry_d;
    end
  end

  // Fetch commits only on a completed access that is not pre-empted by interrupt or reset
  assign fetch_go  = MIO_ready && !int_take && !reset;
  assign state_out = state_q;
  assign cause     = cause_q;

  // Datapath control decode from the current state
  always_comb begin
    MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; IorD = 1'b0; CPU_MIO = 1'b0;
    RegWrite = 1'b0; ALUSrcA = 1'b0; PCWrite = 1'b0; PCWriteCond = 1'b0; Branch = 1'b0;
    RegDst = 2'b00; MemtoReg = 2'b00; ALUSrcB = 2'b00; PCSource = 2'b00;
    EPCWrite = 1'b0; int_ack = 1'b0; aluop = 2'b00;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1; CPU_MIO = 1'b1; ALUSrcB = 2'b01;
        PCWrite = fetch_go; IRWrite = fetch_go;
      end
      S_ID:     ALUSrcB = 2'b11;
      S_MEM_EX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      S_MEM_RD: begin MemRead = 1'b1; IorD = 1'b1; CPU_MIO = 1'b1; end
      S_LW_WB:  begin RegWrite = 1'b1; MemtoReg = 2'b01; end
      S_MEM_W:  begin MemWrite = 1'b1; IorD = 1'b1; CPU_MIO = 1'b1; end
      S_R_EXC:  begin ALUSrcA = 1'b1; aluop = 2'b10; end
      S_R_WB:   begin RegWrite = 1'b1; RegDst = 2'b01; ALUSrcA = 1'b1; aluop = 2'b10; end
      S_BEQ:    begin ALUSrcA = 1'b1; aluop = 2'b01; PCWriteCond = 1'b1; Branch = 1'b1; PCSource = 2'b01; end
      S_BNE:    begin ALUSrcA = 1'b1; aluop = 2'b01; PCWriteCond = 1'b1; PCSource = 2'b01; end
      S_J:      begin PCWrite = 1'b1; PCSource = 2'b10; end
      S_I_EXC:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; aluop = 2'b11; end
      S_I_WB:   begin RegWrite = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; aluop = 2'b11; end
      S_LUI:    begin RegWrite = 1'b1; MemtoReg = 2'b10; end
      // jr/jalr encode rt=$0, so A + B passes rs straight to the PC
      S_JR:     begin ALUSrcA = 1'b1; PCWrite = 1'b1; end
      S_JALR:   begin ALUSrcA = 1'b1; PCWrite = 1'b1; RegWrite = 1'b1; RegDst = 2'b01; MemtoReg = 2'b11; end
      S_JAL:    begin PCWrite = 1'b1; PCSource = 2'b10; RegWrite = 1'b1; RegDst = 2'b10; MemtoReg = 2'b11; end
      S_TRAP: begin
        EPCWrite = 1'b1; PCWrite = 1'b1; PCSource = 2'b11;
        int_ack  = INT_EN && (cause_q == 2'd0);
      end
      default: ;
    endcase
  end

  // ALU operation from ALUop, funct and opcode
  always_comb begin
    ALU_operation = A_ADD;
    case (aluop)
      2'b01: ALU_operation = A_SUB;
      2'b10: begin
        case (funct)
          F_SUB: ALU_operation = A_SUB;
          F_AND: ALU_operation = A_AND;
          F_OR:  ALU_operation = A_OR;
          F_NOR: ALU_operation = A_NOR;
          F_SLT: ALU_operation = A_SLT;
          F_SRL: ALU_operation = A_SRL;
          F_XOR: ALU_operation = A_XOR;
          default: ALU_operation = A_ADD;
        endcase
      end
      2'b11: begin
        case (op)
          OP_ANDI: ALU_operation = A_AND;
          OP_ORI:  ALU_operation = A_OR;
          OP_XORI: ALU_operation = A_XOR;
          OP_SLTI: ALU_operation = A_SLT;
          default: ALU_operation = A_ADD;
        endcase
      end
      default: ALU_operation = A_ADD;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_trap.sv
// Directed bench for mc_ctrl_trap: a per-cycle vector table plus hand-written
// sequences for timeout, interrupt masking, overflow masking and async reset.
module tb_mc_ctrl_trap;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] Inst_in;
  logic zero, overflow, MIO_ready, int_req;

  logic int_ack, EPCWrite, MemRead, MemWrite, IRWrite, IorD, CPU_MIO, RegWrite, ALUSrcA;
  logic PCWrite, PCWriteCond, Branch;
  logic [1:0] cause, RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [4:0] state_out;
  logic [2:0] ALU_operation;

  logic b_int_ack, b_EPCWrite, b_MemRead, b_MemWrite, b_IRWrite, b_IorD, b_CPU_MIO, b_RegWrite;
  logic b_ALUSrcA, b_PCWrite, b_PCWriteCond, b_Branch;
  logic [1:0] b_cause, b_RegDst, b_MemtoReg, b_ALUSrcB, b_PCSource;
  logic [4:0] b_state_out;
  logic [2:0] b_ALU_operation;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_ctrl_trap #(.MEM_TIMEOUT(4), .TRAP_OVF(1'b1), .INT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .int_req(int_req), .int_ack(int_ack), .cause(cause),
    .EPCWrite(EPCWrite), .state_out(state_out), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .IorD(IorD), .CPU_MIO(CPU_MIO), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALU_operation(ALU_operation));

  mc_ctrl_trap #(.MEM_TIMEOUT(0), .TRAP_OVF(1'b0), .INT_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .int_req(int_req), .int_ack(b_int_ack), .cause(b_cause),
    .EPCWrite(b_EPCWrite), .state_out(b_state_out), .MemRead(b_MemRead), .MemWrite(b_MemWrite),
    .IRWrite(b_IRWrite), .IorD(b_IorD), .CPU_MIO(b_CPU_MIO), .RegWrite(b_RegWrite),
    .ALUSrcA(b_ALUSrcA), .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond), .Branch(b_Branch),
    .RegDst(b_RegDst), .MemtoReg(b_MemtoReg), .ALUSrcB(b_ALUSrcB), .PCSource(b_PCSource),
    .ALU_operation(b_ALU_operation));

  localparam logic [31:0] I_LW = 32'h8C000000, I_SW = 32'hAC000000, I_ADD = 32'h00000020,
    I_SUB = 32'h00000022, I_ILL = 32'hFC000000, I_ORI = 32'h34000000, I_BEQ = 32'h10000000,
    I_BNE = 32'h14000000, I_J = 32'h08000000;

  // ctl = {MemRead, MemWrite, IRWrite, IorD, PCWrite, PCWriteCond, Branch, RegWrite, EPCWrite, int_ack}
  localparam logic [9:0] C_FETCH = 10'b1010100000, C_NONE = 10'b0000000000,
    C_MRD = 10'b1001000000, C_MWR = 10'b0101000000, C_RW = 10'b0000000100,
    C_IFST = 10'b1000000000, C_TRAP = 10'b0000100010, C_TRAPI = 10'b0000100011,
    C_BEQ = 10'b0000011000, C_BNE = 10'b0000010000, C_J = 10'b0000100000;

  typedef struct {
    logic [31:0] inst;
    logic        ovf, rdy, irq;
    logic [4:0]  st;
    logic [9:0]  ctl;
    logic [1:0]  cs;
    logic        ca;
    logic [2:0]  alu;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [31:0] i, input logic o, input logic r, input logic q,
                     input logic [4:0] s, input logic [9:0] c, input logic [1:0] cs,
                     input logic ca, input logic [2:0] alu);
    vec_t v;
    v.inst = i; v.ovf = o; v.rdy = r; v.irq = q; v.st = s; v.ctl = c; v.cs = cs; v.ca = ca; v.alu = alu;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic o, input logic r, input logic q);
    Inst_in = i; overflow = o; MIO_ready = r; int_req = q;
    #2;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; MIO_ready = 1'b0; int_req = 1'b0; overflow = 1'b0; Inst_in = '0;
    #2;
    reset = 1'b0;
  endtask

  function automatic logic [9:0] ctl_a();
    return {MemRead, MemWrite, IRWrite, IorD, PCWrite, PCWriteCond, Branch, RegWrite, EPCWrite, int_ack};
  endfunction

  initial begin
    reset = 1'b1; Inst_in = '0; zero = 1'b0; overflow = 1'b0; MIO_ready = 1'b1; int_req = 1'b0;

    // lw with three wait cycles in MEM_RD; ready on the last allowed count wins
    add(I_LW, 0, 1, 0, 5'd0, C_FETCH, 2'd0, 0, 3'd0);
    add(I_LW, 0, 0, 0, 5'd1, C_NONE, 2'd0, 0, 3'd0);
    add(I_LW, 0, 0, 0, 5'd2, C_NONE, 2'd0, 0, 3'd0);
    add(I_LW, 0, 0, 0, 5'd3, C_MRD, 2'd0, 0, 3'd0);
    add(I_LW, 0, 0, 0, 5'd3, C_MRD, 2'd0, 0, 3'd0);
    add(I_LW, 0, 0, 0, 5'd3, C_MRD, 2'd0, 0, 3'd0);
    add(I_LW, 0, 1, 0, 5'd3, C_MRD, 2'd0, 0, 3'd0);
    add(I_LW, 0, 1, 0, 5'd4, C_RW, 2'd0, 0, 3'd0);
    add(I_LW, 0, 0, 0, 5'd0, C_IFST, 2'd0, 0, 3'd0);
    // add overflow traps with cause 2
    add(I_ADD, 0, 1, 0, 5'd0, C_FETCH, 2'd0, 0, 3'd0);
    add(I_ADD, 0, 0, 0, 5'd1, C_NONE, 2'd0, 0, 3'd0);
    add(I_ADD, 1, 0, 0, 5'd6, C_NONE, 2'd0, 1, 3'b010);
    add(I_ADD, 0, 1, 0, 5'd17, C_TRAP, 2'd2, 0, 3'd0);
    // illegal opcode 0x3F traps with cause 1
    add(I_ILL, 0, 1, 0, 5'd0, C_FETCH, 2'd2, 0, 3'd0);
    add(I_ILL, 0, 0, 0, 5'd1, C_NONE, 2'd2, 0, 3'd0);
    add(I_ILL, 0, 1, 0, 5'd17, C_TRAP, 2'd1, 0, 3'd0);
    // sw completes immediately
    add(I_SW, 0, 1, 0, 5'd0, C_FETCH, 2'd1, 0, 3'd0);
    add(I_SW, 0, 0, 0, 5'd1, C_NONE, 2'd1, 0, 3'd0);
    add(I_SW, 0, 0, 0, 5'd2, C_NONE, 2'd1, 0, 3'd0);
    add(I_SW, 0, 1, 0, 5'd5, C_MWR, 2'd1, 0, 3'd0);
    // ori ignores overflow
    add(I_ORI, 0, 1, 0, 5'd0, C_FETCH, 2'd1, 0, 3'd0);
    add(I_ORI, 0, 0, 0, 5'd1, C_NONE, 2'd1, 0, 3'd0);
    add(I_ORI, 1, 0, 0, 5'd10, C_NONE, 2'd1, 1, 3'b001);
    add(I_ORI, 0, 0, 0, 5'd11, C_RW, 2'd1, 0, 3'd0);
    // beq then interrupt on the following IF entry
    add(I_BEQ, 0, 1, 0, 5'd0, C_FETCH, 2'd1, 0, 3'd0);
    add(I_BEQ, 0, 0, 0, 5'd1, C_NONE, 2'd1, 0, 3'd0);
    add(I_BEQ, 0, 0, 1, 5'd8, C_BEQ, 2'd1, 1, 3'b110);
    add(I_BEQ, 0, 1, 1, 5'd0, C_IFST, 2'd1, 0, 3'd0);
    add(I_BEQ, 0, 1, 0, 5'd17, C_TRAPI, 2'd0, 0, 3'd0);
    // bne, sub, j
    add(I_BNE, 0, 1, 0, 5'd0, C_FETCH, 2'd0, 0, 3'd0);
    add(I_BNE, 0, 0, 0, 5'd1, C_NONE, 2'd0, 0, 3'd0);
    add(I_BNE, 0, 0, 0, 5'd13, C_BNE, 2'd0, 1, 3'b110);
    add(I_SUB, 0, 1, 0, 5'd0, C_FETCH, 2'd0, 0, 3'd0);
    add(I_SUB, 0, 0, 0, 5'd1, C_NONE, 2'd0, 0, 3'd0);
    add(I_SUB, 0, 0, 0, 5'd6, C_NONE, 2'd0, 1, 3'b110);
    add(I_SUB, 0, 0, 0, 5'd7, C_RW, 2'd0, 0, 3'd0);
    add(I_J, 0, 1, 0, 5'd0, C_FETCH, 2'd0, 0, 3'd0);
    add(I_J, 0, 0, 0, 5'd1, C_NONE, 2'd0, 0, 3'd0);
    add(I_J, 0, 0, 0, 5'd9, C_J, 2'd0, 0, 3'd0);

    // Reset state with MIO_ready high: no fetch may commit
    #3;
    check("rst state", 32'(state_out), 32'd0);
    check("rst cause", 32'(cause), 32'd0);
    check("rst PCWrite", 32'(PCWrite), 32'd0);
    check("rst IRWrite", 32'(IRWrite), 32'd0);
    check("rst MemRead", 32'(MemRead), 32'd1);
    check("rst IorD", 32'(IorD), 32'd0);
    check("rst CPU_MIO", 32'(CPU_MIO), 32'd1);
    check("rst ALUSrcB", 32'(ALUSrcB), 32'd1);
    check("rst MemWrite", 32'(MemWrite), 32'd0);
    #7;
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].inst, vecs[i].ovf, vecs[i].rdy, vecs[i].irq);
      check($sformatf("v%0d state", i), 32'(state_out), 32'(vecs[i].st));
      check($sformatf("v%0d ctl", i), 32'(ctl_a()), 32'(vecs[i].ctl));
      check($sformatf("v%0d cause", i), 32'(cause), 32'(vecs[i].cs));
      if (vecs[i].ca) check($sformatf("v%0d alu", i), 32'(ALU_operation), 32'(vecs[i].alu));
      adv();
    end

    // Bus timeout in IF (MEM_TIMEOUT=4); the MEM_TIMEOUT=0 instance waits forever
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive('0, 0, 0, 0);
      check($sformatf("to IF%0d state", k), 32'(state_out), 32'd0);
      check($sformatf("to IF%0d PCWrite", k), 32'(PCWrite), 32'd0);
      adv();
    end
    drive('0, 0, 0, 0);
    check("to trap state", 32'(state_out), 32'd17);
    check("to trap cause", 32'(cause), 32'd3);
    check("to trap EPCWrite", 32'(EPCWrite), 32'd1);
    check("to b state", 32'(b_state_out), 32'd0);
    adv();

    // Interrupt after beq: honoured by dut, ignored when INT_EN=0
    do_reset();
    drive(I_BEQ, 0, 1, 0); adv();
    drive(I_BEQ, 0, 0, 0); adv();
    drive(I_BEQ, 0, 0, 1);
    check("irq beq state", 32'(state_out), 32'd8);
    check("irq b beq state", 32'(b_state_out), 32'd8);
    adv();
    drive(I_BEQ, 0, 1, 1);
    check("irq IF PCWrite", 32'(PCWrite), 32'd0);
    check("irq b IF PCWrite", 32'(b_PCWrite), 32'd1);
    adv();
    drive(I_BEQ, 0, 1, 0);
    check("irq trap state", 32'(state_out), 32'd17);
    check("irq int_ack", 32'(int_ack), 32'd1);
    check("irq b state", 32'(b_state_out), 32'd1);
    check("irq b int_ack", 32'(b_int_ack), 32'd0);
    adv();

    // Overflow on add: trap with TRAP_OVF=1, writeback with TRAP_OVF=0
    do_reset();
    drive(I_ADD, 0, 1, 0); adv();
    drive(I_ADD, 0, 0, 0); adv();
    drive(I_ADD, 1, 0, 0);
    check("ovf R_EXC RegWrite", 32'(RegWrite), 32'd0);
    adv();
    drive(I_ADD, 0, 0, 0);
    check("ovf trap state", 32'(state_out), 32'd17);
    check("ovf trap RegWrite", 32'(RegWrite), 32'd0);
    check("ovf b state", 32'(b_state_out), 32'd7);
    check("ovf b RegWrite", 32'(b_RegWrite), 32'd1);
    check("ovf b cause", 32'(b_cause), 32'd0);
    adv();

    // Asynchronous reset during MEM_W
    do_reset();
    drive(I_SW, 0, 1, 0); adv();
    drive(I_SW, 0, 0, 0); adv();
    drive(I_SW, 0, 0, 0); adv();
    drive(I_SW, 0, 0, 0);
    check("mw state", 32'(state_out), 32'd5);
    check("mw MemWrite", 32'(MemWrite), 32'd1);
    MIO_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("arst state", 32'(state_out), 32'd0);
    check("arst MemWrite", 32'(MemWrite), 32'd0);
    check("arst PCWrite", 32'(PCWrite), 32'd0);
    check("arst EPCWrite", 32'(EPCWrite), 32'd0);
    MIO_ready = 1'b0;
    reset = 1'b0;
    adv();
    drive(I_SW, 0, 0, 0);
    check("post arst state", 32'(state_out), 32'd0);
    check("post arst MemWrite", 32'(MemWrite), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
